// File: rtl/multiplicador_uc.sv
// Moore control unit for the shift-and-add multiplier datapath.
// Sequences load, test, add and shift steps behind a start/ready/done handshake.
module multiplicador_uc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic abort_i,
  input  logic qlsb_i,
  input  logic zero_i,
  output logic a_rst_o,
  output logic a_ld_o,
  output logic a_en_o,
  output logic b_ld_o,
  output logic b_en_o,
  output logic q_ld_o,
  output logic q_en_o,
  output logic cnt_ld_o,
  output logic cnt_en_o,
  output logic ready_o,
  output logic busy_o,
  output logic done_o
);

  // The iteration count lives in the datapath counter preset; only sanity-check it here.
  if (WIDTH < 1) begin : g_width_check
    $error("multiplicador_uc: WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StTest  = 3'd2,
    StAdd   = 3'd3,
    StShift = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (!abort_i) begin
      case (state_q)
        StIdle:  state_d = start_i ? StLoad : StIdle;
        StLoad:  state_d = StTest;
        StTest:  state_d = qlsb_i ? StAdd : StShift;
        StAdd:   state_d = StShift;
        StShift: state_d = zero_i ? StDone : StTest;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    a_rst_o  = 1'b0;
    a_ld_o   = 1'b0;
    a_en_o   = 1'b0;
    b_ld_o   = 1'b0;
    b_en_o   = 1'b0;
    q_ld_o   = 1'b0;
    q_en_o   = 1'b0;
    cnt_ld_o = 1'b0;
    cnt_en_o = 1'b0;
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      StIdle: ready_o = 1'b1;
      StLoad: begin
        a_rst_o  = 1'b1;
        b_ld_o   = 1'b1;
        q_ld_o   = 1'b1;
        cnt_ld_o = 1'b1;
        busy_o   = 1'b1;
      end
      StTest: busy_o = 1'b1;
      StAdd: begin
        a_ld_o = 1'b1;
        busy_o = 1'b1;
      end
      StShift: begin
        a_en_o   = 1'b1;
        q_en_o   = 1'b1;
        // Counter holds on the last shift, so zero is seen before any decrement.
        cnt_en_o = ~zero_i;
        busy_o   = 1'b1;
      end
      StDone: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multiplicador_uc.sv
// Scoreboard bench for multiplicador_uc driving a behavioural shift-and-add datapath.
module tb_multiplicador_uc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic qlsb, zero;
  logic a_rst, a_ld, a_en, b_ld, b_en, q_ld, q_en, cnt_ld, cnt_en, ready, busy, done;

  always #5 clk = ~clk;

  multiplicador_uc #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .abort_i  (abort),
    .qlsb_i   (qlsb),
    .zero_i   (zero),
    .a_rst_o  (a_rst),
    .a_ld_o   (a_ld),
    .a_en_o   (a_en),
    .b_ld_o   (b_ld),
    .b_en_o   (b_en),
    .q_ld_o   (q_ld),
    .q_en_o   (q_en),
    .cnt_ld_o (cnt_ld),
    .cnt_en_o (cnt_en),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done)
  );

  // Datapath model; A carries one extra bit for the adder carry-out.
  int unsigned w_cur = 8;
  logic [7:0] b_in = '0, q_in = '0;
  logic [8:0] a_q;
  logic [7:0] b_q, q_q;
  logic [3:0] cnt_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; q_q <= '0; cnt_q <= '0;
    end else begin
      if (a_rst) a_q <= '0;
      else if (a_ld) a_q <= a_q + {1'b0, b_q};
      else if (a_en) a_q <= a_q >> 1;
      if (b_ld) b_q <= b_in;
      if (q_ld) q_q <= q_in;
      else if (q_en) q_q <= (q_q >> 1) | (8'(a_q[0]) << (w_cur - 1));
      if (cnt_ld) cnt_q <= 4'(w_cur - 1);
      else if (cnt_en) cnt_q <= cnt_q - 4'd1;
    end
  end

  assign qlsb = q_q[0];
  assign zero = (cnt_q == 4'd0);

  function automatic logic [15:0] p_out();
    logic [7:0] mask;
    mask = 8'((1 << w_cur) - 1);
    return (16'(a_q[7:0] & mask) << w_cur) | 16'(q_q);
  endfunction

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] p;
    int lat;
    int adds;
    int launch;
  } exp_t;
  exp_t sb[$];

  // Monitor: pops one expectation per done pulse.
  int  acnt = 0;
  bit  chk_ready_next = 0;
  always @(negedge clk) begin
    if (chk_ready_next) begin
      check("ready_after_done", {31'd0, ready}, 32'd1);
      chk_ready_next = 0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done high with no run pending (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", {16'd0, p_out()}, {16'd0, e.p});
        check("latency", edge_cnt - e.launch, e.lat);
        check("add_cycles", acnt, e.adds);
        check("b_en_low", {31'd0, b_en}, 32'd0);
        chk_ready_next = 1;
      end
    end
    if (ready) acnt = 0;
    else if (a_ld) acnt++;
  end

  // Leaves the bench at the negedge after the start edge, i.e. with the DUT in LOAD.
  task automatic launch(input logic [7:0] b, input logic [7:0] q, input int unsigned w,
                        input logic [15:0] exp_p, input int adds, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_before_launch", {31'd0, ready}, 32'd1);
    b_in = b;
    q_in = q;
    w_cur = w;
    start = 1'b1;
    if (push) sb.push_back('{p: exp_p, lat: 1 + 2 * int'(w) + adds, adds: adds,
                             launch: edge_cnt + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("run_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_high(input string name, ref logic sig);
    int n;
    n = 0;
    while (!sig && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sig) check(name, {31'd0, sig}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_outputs",
          {20'd0, a_rst, a_ld, a_en, b_ld, b_en, q_ld, q_en, cnt_ld, cnt_en, ready, busy, done},
          32'b0000_0000_0100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);

    // 3 x 5, checking the LOAD strobes on the way.
    launch(8'd3, 8'd5, 8, 16'd15, 2, 1);
    check("load_strobes",
          {20'd0, a_rst, a_ld, a_en, b_ld, b_en, q_ld, q_en, cnt_ld, cnt_en, ready, busy, done},
          32'b1001_0101_0010);
    drain();

    launch(8'hFF, 8'hFF, 8, 16'hFE01, 8, 1);
    drain();
    launch(8'hA5, 8'h00, 8, 16'h0000, 0, 1);
    drain();
    launch(8'h80, 8'h81, 8, 16'h4080, 2, 1);
    drain();

    // Stray start pulse three cycles after LOAD must be ignored.
    launch(8'd3, 8'd5, 8, 16'd15, 2, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of a SHIFT.
    launch(8'hFF, 8'hFF, 8, 16'h0, 0, 0);
    wait_high("wait_shift", a_en);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ready", {31'd0, ready}, 32'd1);
    check("rst_async_strobes", {29'd0, busy, a_en, q_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(8'd12, 8'd10, 8, 16'd120, 2, 1);
    drain();

    // Abort during ADD: back to IDLE, no done.
    launch(8'hFF, 8'h0F, 8, 16'h0, 0, 0);
    wait_high("wait_add", a_ld);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_strobes", {30'd0, busy, a_ld}, 32'd0);
    repeat (30) @(negedge clk);
    launch(8'd7, 8'd9, 4, 16'd63, 2, 1);
    drain();

    // start with abort in IDLE stays in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_start_idle", {30'd0, ready, busy}, 32'b10);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
